sarlock_key_loader: RTL and testbench
=====================================

# sarlock_key_loader

Sequential key-provisioning stage directly upstream of the SARLock-locked c432 combinational core. It receives the secret key as a serial bitstream with a trailing even-parity bit, assembles it in a shadow register, and commits it atomically to the `key` bus that drives the core's `keyinput0..keyinput31`. A half-loaded or corrupted key never reaches the core.

## Interface
Parameters:
- `KEY_W`, 32, key width; bit i drives `keyinput<i>`.
- `MAX_FAIL`, 3, consecutive parity failures before lockout (used only with the lockout macro).

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `load_start` input 1: one-cycle request to begin a load.
- `key_bit` input 1: serial data, key LSB first, then the parity bit.
- `key_valid` input 1: qualifies `key_bit` for the current cycle.
- `key` output KEY_W: committed key driven to the locked core.
- `key_loaded` output 1: high once a key has been committed; sticky until reset.
- `busy` output 1: high in SHIFT and CHECK.
- `load_ok` output 1: one-cycle pulse on commit.
- `load_err` output 1: one-cycle pulse on parity failure.
- `locked_out` output 1: lockout state; constant 0 without the macro.

## Operation
- FSM states: IDLE, SHIFT, CHECK, LOCKOUT.
- IDLE + `load_start` → SHIFT. Clear the bit counter, the shadow register, and the running parity.
- SHIFT: on each `key_valid` cycle, write `key_bit` into shadow[cnt] and XOR it into the parity. Bits 0..KEY_W-1 are key bits; bit KEY_W is the parity bit. After the (KEY_W+1)th valid bit, go to CHECK. Cycles with `key_valid` low are stalls and change nothing.
- `load_start` during SHIFT restarts the load: counter, shadow and parity clear, and the state stays SHIFT. `key_valid` in the same cycle is ignored.
- CHECK, one cycle:
  - Parity is even (XOR of all KEY_W+1 bits is 0): `key` ← shadow, `key_loaded` ← 1, pulse `load_ok`, clear the fail counter, return to IDLE.
  - Parity is odd: `key` is unchanged, pulse `load_err`, increment the fail counter (saturating), return to IDLE, or go to LOCKOUT if the macro is set and the count reaches MAX_FAIL.
- `key` changes only in CHECK on success. Reloading a new key is allowed at any time from IDLE.
- `load_start` in CHECK or LOCKOUT is ignored. `key_valid` outside SHIFT is ignored.
- Counter width is $clog2(KEY_W+1). The counter never exceeds KEY_W.

## Timing
- Reset values: `key`=0, `key_loaded`=0, `busy`=0, `load_ok`=0, `load_err`=0, `locked_out`=0, state IDLE, fail counter 0.
- Reset asserted mid-load discards the shadow. `key` returns to 0 asynchronously.
- `load_start` at edge t puts the state in SHIFT from t+1. The first bit can be accepted at edge t+1.
- Last valid bit at edge n: CHECK during cycle n+1. `key`, `load_ok` and `load_err` update at edge n+2.
- Minimum load is KEY_W+3 cycles from `load_start` to the committed `key`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SARLOCK_KEY_LOCKOUT_EN` defined: after MAX_FAIL consecutive parity failures, enter LOCKOUT. In LOCKOUT, `locked_out`=1, `key` is forced to 0, `key_loaded`=0, and all inputs are ignored until `rst_n` is asserted.
- Not defined: there is no LOCKOUT state and no fail counter. A parity failure only pulses `load_err`. `locked_out` is tied to 0.

## Structure
- Package `sarlock_key_pkg`: the state enum `key_ld_state_e`, default `KEY_W`, `MAX_FAIL`, and the counter-width localparam.
- One sub-module, `key_shift_reg`: the indexed shadow register with clear, valid-qualified write and running parity. The FSM, fail counter and commit logic live in the top module.

## Test plan
- Load key 0x0000_0001 with parity bit 1, `key_valid` continuous → `load_ok` at cycle 35 after `load_start`, `key`=0x0000_0001, `key_loaded`=1.
- Load 0xFFFF_FFFF with parity bit 1 → `load_err` pulse, `key` keeps its previous value 0x0000_0001.
- Load 0xA5A5_5A5A with `key_valid` low on every other cycle → committed `key`=0xA5A5_5A5A. `busy` stays high throughout the stalls.
- `load_start` re-asserted after 10 bits, then a full 0x1234_5678 load with parity 1 → `key`=0x1234_5678. None of the first 10 bits leak into the result.
- Assert `rst_n` low after 20 bits of a load → all outputs are 0 immediately, and the state is IDLE after release.
- With `SARLOCK_KEY_LOCKOUT_EN`: three bad-parity loads → `locked_out`=1, `key`=0. A following good load is ignored; a reset clears the lockout.

Source files
------------

// File: rtl/sarlock_key_pkg.sv
// Shared types and defaults for the SARLock key loader: FSM state encoding,
// default key width / failure limit and the bit-counter width helper.
package sarlock_key_pkg;

    localparam int KEY_W_DEF    = 32;
    localparam int MAX_FAIL_DEF = 3;
    localparam int KEY_CNT_W    = $clog2(KEY_W_DEF + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CHECK   = 2'd2,
        LOCKOUT = 2'd3
    } key_ld_state_e;

    // Counter must index KEY_W key bits plus the trailing parity bit.
    function automatic int cnt_width(input int key_w);
        return $clog2(key_w + 1);
    endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Indexed shadow register for the serial key: clear, valid-qualified write of
// bit cnt, running XOR parity and a done flag after the (KEY_W+1)th bit.
module key_shift_reg
    import sarlock_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic             bit_i,
    output logic [KEY_W-1:0] shadow_o,
    output logic             parity_o,
    output logic             done_o
);

    localparam int CNT_W = cnt_width(KEY_W);

    logic [CNT_W-1:0] cnt_q;
    logic             parity_q;
    logic             done_q;
    logic             accept;

    // Once the parity bit is in, further valid bits are dropped and cnt stays at KEY_W.
    assign accept = wr_en_i && !done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (clr_i) begin
            cnt_q    <= '0;
            parity_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (accept) begin
            parity_q <= parity_q ^ bit_i;
            if (cnt_q == CNT_W'(KEY_W)) begin
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < KEY_W; gi++) begin : g_bit
            logic bit_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    bit_q <= 1'b0;
                end else if (clr_i) begin
                    bit_q <= 1'b0;
                end else if (accept && (cnt_q == CNT_W'(gi))) begin
                    bit_q <= bit_i;
                end
            end
            assign shadow_o[gi] = bit_q;
        end
    endgenerate

    assign parity_o = parity_q;
    assign done_o   = done_q;

endmodule

// File: rtl/sarlock_key_loader.sv
// Serial key loader feeding the SARLock c432 key bus; commits only on even parity.
// Optional macro SARLOCK_KEY_LOCKOUT_EN adds a lockout after MAX_FAIL bad loads.
module sarlock_key_loader
    import sarlock_key_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int MAX_FAIL = MAX_FAIL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             key_bit,
    input  logic             key_valid,
    output logic [KEY_W-1:0] key,
    output logic             key_loaded,
    output logic             busy,
    output logic             load_ok,
    output logic             load_err,
    output logic             locked_out
);

    key_ld_state_e    state_q;
    logic [KEY_W-1:0] key_q;
    logic             key_loaded_q;
    logic             busy_q;
    logic             load_ok_q;
    logic             load_err_q;
    logic             locked_out_q;

    logic [KEY_W-1:0] shadow;
    logic             sh_parity;
    logic             sh_done;
    logic             sh_clr;
    logic             sh_wr;

    // A restart in SHIFT clears the shadow and swallows that cycle's key_valid.
    assign sh_clr = load_start && ((state_q == IDLE) || (state_q == SHIFT));
    assign sh_wr  = (state_q == SHIFT) && key_valid && !load_start;

    key_shift_reg #(
        .KEY_W (KEY_W)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (sh_clr),
        .wr_en_i  (sh_wr),
        .bit_i    (key_bit),
        .shadow_o (shadow),
        .parity_o (sh_parity),
        .done_o   (sh_done)
    );

`ifdef SARLOCK_KEY_LOCKOUT_EN
    localparam int FAIL_CNT_W = $clog2(MAX_FAIL + 1);
    logic [FAIL_CNT_W-1:0] fail_cnt_q;
    logic [FAIL_CNT_W-1:0] fail_inc;
    assign fail_inc = (fail_cnt_q == FAIL_CNT_W'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + 1'b1;
`else
    // MAX_FAIL has no effect without the lockout feature.
    logic unused_max_fail;
    assign unused_max_fail = (MAX_FAIL > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            key_q        <= '0;
            key_loaded_q <= 1'b0;
            busy_q       <= 1'b0;
            load_ok_q    <= 1'b0;
            load_err_q   <= 1'b0;
            locked_out_q <= 1'b0;
`ifdef SARLOCK_KEY_LOCKOUT_EN
            fail_cnt_q   <= '0;
`endif
        end else begin
            load_ok_q  <= 1'b0;
            load_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (!load_start && sh_done) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!sh_parity) begin
                        key_q        <= shadow;
                        key_loaded_q <= 1'b1;
                        load_ok_q    <= 1'b1;
`ifdef SARLOCK_KEY_LOCKOUT_EN
                        fail_cnt_q   <= '0;
`endif
                    end else begin
                        load_err_q <= 1'b1;
`ifdef SARLOCK_KEY_LOCKOUT_EN
                        fail_cnt_q <= fail_inc;
                        if (fail_inc == FAIL_CNT_W'(MAX_FAIL)) begin
                            state_q      <= LOCKOUT;
                            locked_out_q <= 1'b1;
                            key_q        <= '0;
                            key_loaded_q <= 1'b0;
                        end
`endif
                    end
                end
                LOCKOUT: begin
`ifndef SARLOCK_KEY_LOCKOUT_EN
                    state_q <= IDLE;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key        = key_q;
    assign key_loaded = key_loaded_q;
    assign busy       = busy_q;
    assign load_ok    = load_ok_q;
    assign load_err   = load_err_q;
    assign locked_out = locked_out_q;

endmodule

// File: tb/tb_sarlock_key_loader.sv
// Directed, table-driven bench for sarlock_key_loader; inputs change and outputs
// are sampled on the falling clock edge.
module tb_sarlock_key_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        key_bit = 1'b0;
    logic        key_valid = 1'b0;
    logic [31:0] key;
    logic        key_loaded, busy, load_ok, load_err, locked_out;

    always #5 clk = ~clk;

    sarlock_key_loader #(
        .KEY_W    (32),
        .MAX_FAIL (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .key_bit    (key_bit),
        .key_valid  (key_valid),
        .key        (key),
        .key_loaded (key_loaded),
        .busy       (busy),
        .load_ok    (load_ok),
        .load_err   (load_err),
        .locked_out (locked_out)
    );

    int n_vec = 0;
    int n_err = 0;

    // Observations collected by step() during one load.
    int e_cnt, r_ok, r_err, r_edge;
    bit track_busy, r_busy_all, r_busy_any;

    typedef struct {
        logic [31:0] k;
        logic        par;
        bit          stall;
        bit          restart;
        bit          exp_ok;
        logic [31:0] exp_key;
        int          exp_edge;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(negedge clk);
        e_cnt++;
        if (load_ok) begin
            r_ok++;
            r_edge = e_cnt;
        end
        if (load_err) begin
            r_err++;
            r_edge = e_cnt;
        end
        if (track_busy) begin
            if (!busy) r_busy_all = 1'b0;
            if (busy)  r_busy_any = 1'b1;
        end
    endtask

    // Edge counting starts at the edge that samples load_start (edge 0).
    task automatic run_load(input logic [31:0] k, input logic par, input bit stall, input bit restart);
        logic b;
        e_cnt = 0; r_ok = 0; r_err = 0; r_edge = -1;
        r_busy_all = 1'b1; r_busy_any = 1'b0; track_busy = 1'b0;
        @(negedge clk);
        load_start = 1'b1;
        key_valid  = 1'b0;
        @(negedge clk);
        load_start = 1'b0;
        track_busy = 1'b1;
        if (restart) begin
            for (int i = 0; i < 10; i++) begin
                key_valid = 1'b1; key_bit = 1'b1;
                step();
            end
            load_start = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
            step();
            load_start = 1'b0;
        end
        for (int i = 0; i <= 32; i++) begin
            b = (i < 32) ? k[i] : par;
            if (stall && i > 0) begin
                key_valid = 1'b0; key_bit = ~b;
                step();
            end
            key_valid = 1'b1; key_bit = b;
            step();
        end
        key_valid  = 1'b0;
        track_busy = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        vecs[0] = '{32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0001, 35};
        vecs[1] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 35};
        vecs[2] = '{32'hA5A5_5A5A, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA5A5_5A5A, 67};
        vecs[3] = '{32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 46};
        vecs[4] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 35};
        vecs[5] = '{32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 35};
        vecs[6] = '{32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 35};

        repeat (3) @(negedge clk);
        check("rst key", key, 32'h0);
        check("rst key_loaded", {31'b0, key_loaded}, 32'h0);
        check("rst busy", {31'b0, busy}, 32'h0);
        check("rst load_ok", {31'b0, load_ok}, 32'h0);
        check("rst load_err", {31'b0, load_err}, 32'h0);
        check("rst locked_out", {31'b0, locked_out}, 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            run_load(vecs[v].k, vecs[v].par, vecs[v].stall, vecs[v].restart);
            check($sformatf("v%0d load_ok count", v), r_ok, vecs[v].exp_ok ? 1 : 0);
            check($sformatf("v%0d load_err count", v), r_err, vecs[v].exp_ok ? 0 : 1);
            check($sformatf("v%0d pulse edge", v), r_edge, vecs[v].exp_edge);
            check($sformatf("v%0d key", v), key, vecs[v].exp_key);
            check($sformatf("v%0d key_loaded", v), {31'b0, key_loaded}, 32'h1);
            check($sformatf("v%0d busy during load", v), {31'b0, r_busy_all}, 32'h1);
            check($sformatf("v%0d busy after", v), {31'b0, busy}, 32'h0);
            check($sformatf("v%0d locked_out", v), {31'b0, locked_out}, 32'h0);
        end

        // Reset in the middle of a load: outputs clear without waiting for a clock.
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            key_valid = 1'b1; key_bit = 1'b1;
            @(negedge clk);
        end
        key_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst key", key, 32'h0);
        check("midrst key_loaded", {31'b0, key_loaded}, 32'h0);
        check("midrst busy", {31'b0, busy}, 32'h0);
        check("midrst load_ok/err", {30'b0, load_ok, load_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("postrst busy", {31'b0, busy}, 32'h0);
        run_load(32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        check("postrst load_ok edge", r_edge, 35);
        check("postrst key", key, 32'h0000_00FF);

        // Three consecutive bad-parity loads.
        run_load(32'h0000_000F, 1'b0, 1'b0, 1'b0);
        check("lk good key", key, 32'h0000_000F);
        for (int j = 0; j < 3; j++) begin
            run_load(32'h0000_0007, 1'b0, 1'b0, 1'b0);
            check($sformatf("lk bad%0d load_err count", j), r_err, 1);
        end
`ifdef SARLOCK_KEY_LOCKOUT_EN
        check("lk locked_out", {31'b0, locked_out}, 32'h1);
        check("lk key forced", key, 32'h0);
        check("lk key_loaded", {31'b0, key_loaded}, 32'h0);
        run_load(32'h0000_0003, 1'b0, 1'b0, 1'b0);
        check("lk ignored ok/err", r_ok + r_err, 0);
        check("lk ignored busy", {31'b0, r_busy_any}, 32'h0);
        check("lk ignored key", key, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("lk cleared", {31'b0, locked_out}, 32'h0);
        run_load(32'h0000_0003, 1'b0, 1'b0, 1'b0);
        check("lk after rst key", key, 32'h0000_0003);
`else
        check("nolk locked_out", {31'b0, locked_out}, 32'h0);
        check("nolk key kept", key, 32'h0000_000F);
        check("nolk key_loaded", {31'b0, key_loaded}, 32'h1);
        run_load(32'h0000_0003, 1'b0, 1'b0, 1'b0);
        check("nolk reload key", key, 32'h0000_0003);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
